obi_ahb_master: RTL and testbench
=================================

// Module: obi_ahb_master
// PURPOSE
// Bridges one cv32e40p OBI port (instruction or data) onto an AHB master slot (M1/M2) of ahb_bus.
// Accepts OBI requests, arbitrates via HBUSREQ/HGRANT, runs one AHB address+data phase per request,
// and returns rdata/err on OBI. Sits between the core and ahb_bus; one instance per master slot.
// PARAMETERS
// ADDR_WIDTH    16    AHB address width; OBI addr[31:ADDR_WIDTH] must be zero
// TIMEOUT_CYC   255   max data-phase cycles waiting on HREADY before error; 0 disables timeout
// LOCK_BURST    1     1: keep HBUSREQ/HLOCK high across back-to-back queued requests
// PORTS
// HCLK        in   1            bus clock
// HRESET      in   1            asynchronous, active-high reset
// req_i       in   1            OBI request
// gnt_o       out  1            OBI grant (request accepted this cycle)
// addr_i      in   32           OBI byte address
// we_i        in   1            OBI write enable
// wdata_i     in   32           OBI write data
// rvalid_o    out  1            OBI response valid (1-cycle pulse)
// rdata_o     out  32           OBI read data (valid with rvalid_o)
// err_o       out  1            OBI error (valid with rvalid_o)
// HBUSREQ     out  1            bus request to arbiter
// HLOCK       out  1            locked-transfer request
// HGRANT      in   1            arbiter grant
// HADDR       out  ADDR_WIDTH   AHB address
// HWRITE      out  1            AHB write
// HWDATA      out  32           AHB write data (data phase)
// HRDATA      in   32           AHB read data
// HREADY      in   1            transfer complete / slave ready
// BEHAVIOUR
// - Reset (async, HRESET=1): state IDLE; all outputs 0; request buffer empty; timeout counter 0.
// - Request buffer: 1 entry {addr,we,wdata}. gnt_o = req_i & buffer-empty (combinational).
//   Buffer frees at the cycle its transfer completes, so a new request may be granted that same cycle.
// - Address check at accept: addr_i[31:ADDR_WIDTH]!=0 -> no bus cycle; rvalid_o+err_o next cycle, rdata_o=0.
// - FSM IDLE: buffer valid -> BUSREQ (HBUSREQ=1, HLOCK=LOCK_BURST).
// - BUSREQ: hold HBUSREQ until HGRANT=1 sampled high -> ADDR.
// - ADDR (1 cycle): HADDR=addr[ADDR_WIDTH-1:0], HWRITE=we -> DATA.
// - DATA: HWDATA=wdata held; HADDR/HWRITE held. On HREADY=1: read -> rdata_o<=HRDATA; pulse rvalid_o
//   next cycle, err_o=0; buffer freed. Next: buffer refilled & HGRANT & LOCK_BURST -> ADDR (no rearbitration),
//   else buffer refilled -> BUSREQ, else IDLE (HBUSREQ, HLOCK drop).
// - Timeout: counter increments each DATA cycle with HREADY=0; reaching TIMEOUT_CYC -> rvalid_o+err_o,
//   rdata_o=0, buffer freed, -> IDLE. Counter clears on entering DATA.
// - HGRANT lost in ADDR: abort, stay queued, -> BUSREQ. HGRANT lost in DATA: ignored, finish transfer.
// - Latency: granted-bus read = accept(T0), BUSREQ T1, ADDR T2, DATA T3 (HREADY=1), rvalid T4.
// - Exactly one rvalid_o per gnt_o, in order; max one outstanding transfer.
// - Reset mid-transfer: immediate return to IDLE, response lost, HBUSREQ drops asynchronously.
// - Outputs registered except gnt_o.
// STRUCTURE
// - ahb_pkg: typedef enum {IDLE,BUSREQ,ADDR,DATA} ahb_mst_state_e; typedef struct obi_req_t {addr,we,wdata};
//   constants AHB_DATA_W=32.
// - Sub-module: obi_req_buf (1-entry valid/ready holding register with range check); FSM and timeout in top.
// TESTING
// - Read, HGRANT already 1, HREADY=1, addr 0x0000_0040, HRDATA=0xDEAD_BEEF -> HADDR=0x0040 at T2, rvalid T4 rdata 0xDEADBEEF.
// - Write 0x1234_5678 to 0x0100, HGRANT delayed 3 cycles -> HBUSREQ high 3 cycles, HWDATA=0x12345678 in DATA, err_o=0.
// - HREADY low 4 cycles in DATA -> HADDR/HWDATA held stable, single rvalid after HREADY rises.
// - Back-to-back reads 0x10,0x14 with LOCK_BURST=1 -> HBUSREQ/HLOCK stay high, second ADDR right after first DATA.
// - addr 0x4000_D000 -> no HBUSREQ, rvalid+err_o next cycle; HREADY stuck 0, TIMEOUT_CYC=8 -> err after 8 cycles.
// - HRESET asserted during DATA -> all outputs 0 same cycle, IDLE after release, next request served normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared types and constants for the OBI-to-AHB master bridge.
//   ahb_mst_state_e : bus-side FSM states
//   obi_req_t       : one OBI request as presented by the core
//   addr_in_range() : true when the OBI address fits in the AHB address width
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam int AHB_DATA_W = 32;
    localparam int OBI_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSREQ,
        ADDR,
        DATA
    } ahb_mst_state_e;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [AHB_DATA_W-1:0] wdata;
    } obi_req_t;

    // Every address bit at or above the AHB address width must be zero.
    function automatic logic addr_in_range(input logic [OBI_ADDR_W-1:0] a,
                                           input int                    aw);
        if (aw >= OBI_ADDR_W) begin
            return 1'b1;
        end
        return ((a >> aw) == '0);
    endfunction

endpackage

// File: rtl/obi_req_buf.sv
// ----------------------------------------------------------------------------
// obi_req_buf
// One-entry holding register between the OBI request channel and the AHB
// FSM. Requests whose address does not fit in ADDR_WIDTH are accepted but
// never stored; bad_o flags them so the top can answer with an error.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   req_i, req_pl_i  OBI request strobe and payload {addr, we, wdata}
//   free_i           the stored transfer completes (or times out) this cycle
//   gnt_o            request accepted this cycle (combinational)
//   accept_o         accepted request is in range and will be stored
//   bad_o            accepted request is out of range
//   valid_o          entry holds a pending transfer
//   nxt_addr_o/we_o  entry contents as they will be after this clock edge
//   wdata_o          write data of the current entry
// ----------------------------------------------------------------------------
module obi_req_buf
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  obi_req_t              req_pl_i,
    input  logic                  free_i,
    output logic                  gnt_o,
    output logic                  accept_o,
    output logic                  bad_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] nxt_addr_o,
    output logic                  nxt_we_o,
    output logic [AHB_DATA_W-1:0] wdata_o
);

    logic                  addr_ok;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [AHB_DATA_W-1:0] wdata_q, wdata_d;

    assign addr_ok = addr_in_range(req_pl_i.addr, ADDR_WIDTH);

    // An out-of-range request may only be taken while the entry is truly
    // empty: its error answer is due next cycle and must not collide with
    // the answer of a transfer completing in the same cycle.
    always_comb begin
        gnt_o    = req_i & (~valid_q | (free_i & addr_ok));
        accept_o = gnt_o & addr_ok;
        bad_o    = gnt_o & ~addr_ok;
        valid_d  = valid_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        if (free_i) begin
            valid_d = 1'b0;
        end
        if (accept_o) begin
            valid_d = 1'b1;
            addr_d  = req_pl_i.addr[ADDR_WIDTH-1:0];
            we_d    = req_pl_i.we;
            wdata_d = req_pl_i.wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign valid_o    = valid_q;
    assign nxt_addr_o = addr_d;
    assign nxt_we_o   = we_d;
    assign wdata_o    = wdata_q;

endmodule

// File: rtl/obi_ahb_master.sv
// ----------------------------------------------------------------------------
// obi_ahb_master
// Bridges one cv32e40p OBI port onto an AHB master slot. A request is held in
// a one-entry buffer, the bus is requested via HBUSREQ/HGRANT, one address
// phase and one data phase are run, and the result is returned on OBI as a
// single-cycle rvalid_o pulse. All outputs except gnt_o are registered.
//
// Ports
//   HCLK, HRESET              clock, asynchronous active-high reset
//   req_i/gnt_o               OBI request handshake (gnt_o combinational)
//   addr_i, we_i, wdata_i     OBI request payload
//   rvalid_o, rdata_o, err_o  OBI response
//   HBUSREQ, HLOCK, HGRANT    AHB arbitration
//   HADDR, HWRITE, HWDATA     AHB address / data phase outputs
//   HRDATA, HREADY            AHB read data and transfer-done
// ----------------------------------------------------------------------------
module obi_ahb_master
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter bit LOCK_BURST  = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  HBUSREQ,
    output logic                  HLOCK,
    input  logic                  HGRANT,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY
);

    // The counter only has to reach TIMEOUT_CYC-1; the next stalled cycle
    // is the one that fires the timeout.
    localparam bit TO_EN = (TIMEOUT_CYC != 0);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    ahb_mst_state_e        state_q, state_d;
    logic                  hbusreq_q, hbusreq_d;
    logic                  hlock_q, hlock_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [31:0]           hwdata_q, hwdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;

    obi_req_t              req_pl;
    logic                  buf_accept, buf_bad, buf_valid;
    logic [ADDR_WIDTH-1:0] buf_nxt_addr;
    logic                  buf_nxt_we;
    logic [31:0]           buf_wdata;
    logic                  complete, timeout_hit, buf_free;

    assign req_pl = '{addr: addr_i, we: we_i, wdata: wdata_i};

    obi_req_buf #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_req_buf (
        .clk_i      (HCLK),
        .rst_i      (HRESET),
        .req_i      (req_i),
        .req_pl_i   (req_pl),
        .free_i     (buf_free),
        .gnt_o      (gnt_o),
        .accept_o   (buf_accept),
        .bad_o      (buf_bad),
        .valid_o    (buf_valid),
        .nxt_addr_o (buf_nxt_addr),
        .nxt_we_o   (buf_nxt_we),
        .wdata_o    (buf_wdata)
    );

    assign complete    = (state_q == DATA) & HREADY;
    assign timeout_hit = TO_EN & (state_q == DATA) & ~HREADY & (cnt_q == TO_LAST);
    assign buf_free    = complete | timeout_hit;

    // Next state. IDLE also reacts to a request being accepted this very
    // cycle so that bus request starts one cycle after the OBI grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (buf_valid | buf_accept) begin
                    state_d = BUSREQ;
                end
            end
            BUSREQ: begin
                if (HGRANT) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = HGRANT ? DATA : BUSREQ;
            end
            DATA: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (complete) begin
                    if (buf_accept & HGRANT & LOCK_BURST) begin
                        state_d = ADDR;
                    end else if (buf_accept) begin
                        state_d = BUSREQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered bus outputs are derived from the state being entered, so
    // they line up with the state register rather than lagging it.
    always_comb begin
        hbusreq_d = (state_d != IDLE);
        hlock_d   = hbusreq_d & LOCK_BURST;
        haddr_d   = '0;
        hwrite_d  = 1'b0;
        hwdata_d  = '0;
        if (state_d == ADDR) begin
            haddr_d  = buf_nxt_addr;
            hwrite_d = buf_nxt_we;
        end else if (state_d == DATA) begin
            haddr_d  = haddr_q;
            hwrite_d = hwrite_q;
            hwdata_d = (state_q == DATA) ? hwdata_q : buf_wdata;
        end
    end

    // OBI response and data-phase stall counter.
    always_comb begin
        rvalid_d = complete | timeout_hit | buf_bad;
        err_d    = timeout_hit | buf_bad;
        rdata_d  = rdata_q;
        if (complete & ~hwrite_q) begin
            rdata_d = HRDATA;
        end else if (rvalid_d) begin
            rdata_d = '0;
        end

        cnt_d = cnt_q;
        if (state_q != DATA) begin
            cnt_d = '0;
        end else if (~HREADY) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= IDLE;
            hbusreq_q <= 1'b0;
            hlock_q   <= 1'b0;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hbusreq_q <= hbusreq_d;
            hlock_q   <= hlock_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign HBUSREQ  = hbusreq_q;
    assign HLOCK    = hlock_q;
    assign HADDR    = haddr_q;
    assign HWRITE   = hwrite_q;
    assign HWDATA   = hwdata_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_obi_ahb_master.sv
// ----------------------------------------------------------------------------
// tb_obi_ahb_master
// Directed bench for obi_ahb_master (ADDR_WIDTH=16, TIMEOUT_CYC=8,
// LOCK_BURST=1). Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge. Cycle Tn is the cycle after the n-th
// rising edge following the OBI accept in T0.
// ----------------------------------------------------------------------------
module tb_obi_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        HBUSREQ;
    logic        HLOCK;
    logic        HGRANT;
    logic [15:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    obi_ahb_master #(
        .ADDR_WIDTH  (16),
        .TIMEOUT_CYC (8),
        .LOCK_BURST  (1'b1)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HGRANT   (HGRANT),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0;
        HGRANT = 1'b0; HRDATA = '0; HREADY = 1'b1;
        tick(); tick();
        smp();
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL rst_hbusreq: got %b want 0", HBUSREQ); end
        n_checks++; if (HLOCK !== 1'b0) begin n_fail++; $display("FAIL rst_hlock: got %b want 0", HLOCK); end
        n_checks++; if (HADDR !== 16'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
        n_checks++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid_o); end
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
        tick();
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_read();
        tick();
        HGRANT = 1'b1; HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF;
        req_i = 1'b1; addr_i = 32'h0000_0040; we_i = 1'b0; wdata_i = '0;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0; smp();
        n_checks++; if (HBUSREQ !== 1'b1) begin n_fail++; $display("FAIL rd_busreq_t1: got %b want 1", HBUSREQ); end
        n_checks++; if (HADDR !== 16'h0000) begin n_fail++; $display("FAIL rd_haddr_t1: got %h want 0000", HADDR); end
        tick(); smp();
        n_checks++; if (HADDR !== 16'h0040) begin n_fail++; $display("FAIL rd_haddr_t2: got %h want 0040", HADDR); end
        n_checks++; if (HWRITE !== 1'b0) begin n_fail++; $display("FAIL rd_hwrite_t2: got %b want 0", HWRITE); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_t3: got %b want 0", rvalid_o); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid_t4: got %b want 1", rvalid_o); end
        n_checks++; if (rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", rdata_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", err_o); end
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL rd_busreq_drop: got %b want 0", HBUSREQ); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_pulse: got %b want 0", rvalid_o); end
    endtask

    task automatic test_write_delayed_grant();
        tick();
        HGRANT = 1'b0; HREADY = 1'b1;
        req_i = 1'b1; addr_i = 32'h0000_0100; we_i = 1'b1; wdata_i = 32'h1234_5678;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            smp();
            n_checks++; if (HBUSREQ !== 1'b1) begin n_fail++; $display("FAIL wr_busreq_wait%0d: got %b want 1", i, HBUSREQ); end
            n_checks++; if (HADDR !== 16'h0000) begin n_fail++; $display("FAIL wr_haddr_wait%0d: got %h want 0000", i, HADDR); end
        end
        HGRANT = 1'b1;
        tick(); smp();
        n_checks++; if (HADDR !== 16'h0100) begin n_fail++; $display("FAIL wr_haddr: got %h want 0100", HADDR); end
        n_checks++; if (HWRITE !== 1'b1) begin n_fail++; $display("FAIL wr_hwrite: got %b want 1", HWRITE); end
        tick(); smp();
        n_checks++; if (HWDATA !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_hwdata: got %h want 12345678", HWDATA); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid: got %b want 1", rvalid_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", err_o); end
    endtask

    task automatic test_wait_states();
        tick();
        HGRANT = 1'b1; HREADY = 1'b1;
        req_i = 1'b1; addr_i = 32'h0000_0080; we_i = 1'b1; wdata_i = 32'hA5A5_5A5A;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL ws_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        tick(); HREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); smp();
            n_checks++; if (HADDR !== 16'h0080) begin n_fail++; $display("FAIL ws_haddr%0d: got %h want 0080", i, HADDR); end
            n_checks++; if (HWDATA !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL ws_hwdata%0d: got %h want a5a55a5a", i, HWDATA); end
            n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ws_rvalid%0d: got %b want 0", i, rvalid_o); end
        end
        tick(); HREADY = 1'b1; smp();
        n_checks++; if (HWDATA !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL ws_hwdata_last: got %h want a5a55a5a", HWDATA); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ws_rvalid_last: got %b want 0", rvalid_o); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL ws_rvalid_done: got %b want 1", rvalid_o); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL ws_rvalid_single: got %b want 0", rvalid_o); end
    endtask

    task automatic test_back_to_back();
        tick();
        HGRANT = 1'b1; HREADY = 1'b1; HRDATA = 32'h1111_0010;
        req_i = 1'b1; addr_i = 32'h0000_0010; we_i = 1'b0; wdata_i = '0;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", gnt_o); end
        tick(); addr_i = 32'h0000_0014; smp();
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gnt_full: got %b want 0", gnt_o); end
        tick(); smp();
        n_checks++; if (HADDR !== 16'h0010) begin n_fail++; $display("FAIL b2b_haddr0: got %h want 0010", HADDR); end
        tick(); smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0; HRDATA = 32'h2222_0014; smp();
        n_checks++; if (HADDR !== 16'h0014) begin n_fail++; $display("FAIL b2b_haddr1: got %h want 0014", HADDR); end
        n_checks++; if (HBUSREQ !== 1'b1) begin n_fail++; $display("FAIL b2b_busreq: got %b want 1", HBUSREQ); end
        n_checks++; if (HLOCK !== 1'b1) begin n_fail++; $display("FAIL b2b_hlock: got %b want 1", HLOCK); end
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid0: got %b want 1", rvalid_o); end
        n_checks++; if (rdata_o !== 32'h1111_0010) begin n_fail++; $display("FAIL b2b_rdata0: got %h want 11110010", rdata_o); end
        tick(); smp();
        n_checks++; if (HLOCK !== 1'b1) begin n_fail++; $display("FAIL b2b_hlock_data1: got %b want 1", HLOCK); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid_gap: got %b want 0", rvalid_o); end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid1: got %b want 1", rvalid_o); end
        n_checks++; if (rdata_o !== 32'h2222_0014) begin n_fail++; $display("FAIL b2b_rdata1: got %h want 22220014", rdata_o); end
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL b2b_busreq_drop: got %b want 0", HBUSREQ); end
    endtask

    task automatic test_timeout();
        tick();
        HGRANT = 1'b1; HREADY = 1'b0; HRDATA = 32'hFFFF_FFFF;
        req_i = 1'b1; addr_i = 32'h0000_0020; we_i = 1'b0; wdata_i = '0;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL to_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick(); smp();
            n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL to_rvalid_wait%0d: got %b want 0", i, rvalid_o); end
            n_checks++; if (HBUSREQ !== 1'b1) begin n_fail++; $display("FAIL to_busreq_wait%0d: got %b want 1", i, HBUSREQ); end
        end
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL to_rvalid: got %b want 1", rvalid_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err_o); end
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", rdata_o); end
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL to_busreq_drop: got %b want 0", HBUSREQ); end
        HREADY = 1'b1;
    endtask

    task automatic test_bad_addr();
        tick();
        HGRANT = 1'b0; HREADY = 1'b1; HRDATA = 32'h7777_7777;
        req_i = 1'b1; addr_i = 32'h4000_D000; we_i = 1'b0; wdata_i = '0;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL bad_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0; smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL bad_rvalid: got %b want 1", rvalid_o); end
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err_o); end
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL bad_rdata: got %h want 0", rdata_o); end
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL bad_busreq: got %b want 0", HBUSREQ); end
        tick(); smp();
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL bad_busreq_t2: got %b want 0", HBUSREQ); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL bad_rvalid_t2: got %b want 0", rvalid_o); end
    endtask

    task automatic test_reset_mid_transfer();
        tick();
        HGRANT = 1'b1; HREADY = 1'b0;
        req_i = 1'b1; addr_i = 32'h0000_0030; we_i = 1'b1; wdata_i = 32'h0000_55AA;
        tick(); req_i = 1'b0;
        tick();
        tick(); smp();
        n_checks++; if (HWDATA !== 32'h0000_55AA) begin n_fail++; $display("FAIL rm_hwdata_data: got %h want 000055aa", HWDATA); end
        HRESET = 1'b1;
        #1;
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL rm_busreq: got %b want 0", HBUSREQ); end
        n_checks++; if (HLOCK !== 1'b0) begin n_fail++; $display("FAIL rm_hlock: got %b want 0", HLOCK); end
        n_checks++; if (HADDR !== 16'h0) begin n_fail++; $display("FAIL rm_haddr: got %h want 0", HADDR); end
        n_checks++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL rm_hwdata: got %h want 0", HWDATA); end
        n_checks++; if (HWRITE !== 1'b0) begin n_fail++; $display("FAIL rm_hwrite: got %b want 0", HWRITE); end
        tick(); HRESET = 1'b0; HREADY = 1'b1;
        tick(); smp();
        n_checks++; if (HBUSREQ !== 1'b0) begin n_fail++; $display("FAIL rm_idle_busreq: got %b want 0", HBUSREQ); end
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rm_lost_rvalid: got %b want 0", rvalid_o); end
        // A fresh read after release is served with the normal latency.
        tick();
        HRDATA = 32'h0BAD_F00D; req_i = 1'b1; addr_i = 32'h0000_0044; we_i = 1'b0; wdata_i = '0;
        smp();
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        tick(); smp();
        n_checks++; if (HADDR !== 16'h0044) begin n_fail++; $display("FAIL rm_haddr_new: got %h want 0044", HADDR); end
        tick();
        tick(); smp();
        n_checks++; if (rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rm_rvalid_new: got %b want 1", rvalid_o); end
        n_checks++; if (rdata_o !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rm_rdata_new: got %h want 0badf00d", rdata_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write_delayed_grant();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_bad_addr();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
